// File: rtl/xmpl_dsp_sched.sv
// Round-robin scheduler sharing one xmpl DSP datapath among NREQ requesters.
// One command in flight; status (or a timeout error) returns over valid/ready.
module xmpl_dsp_sched #(
  parameter int NREQ    = 4,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*12-1:0]        req_cfg_i,
  input  logic [NREQ*32-1:0]        req_data_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  input  logic [NREQ-1:0]           rsp_ready_i,
  output logic [31:0]               rsp_status_o,
  output logic                      rsp_err_o,
  output logic                      dsp_start_o,
  output logic [11:0]               dsp_cfg_o,
  output logic [31:0]               dsp_data_o,
  input  logic                      dsp_done_i,
  input  logic [31:0]               dsp_status_i,
  output logic                      busy_o,
  output logic [$clog2(NREQ)-1:0]   grant_o
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, grant_q, pick, cand;
  logic            any_req;
  logic [11:0]     cfg_q;
  logic [31:0]     data_q;
  logic [TMO_W-1:0] cnt_q;
  logic [31:0]     status_q;
  logic            err_q;
  logic            tmo_hit;
  logic            rsp_hs;

  // Circular search upward from the round-robin pointer.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = GW'((32'(rr_q) + i) % 32'(NREQ));
      if (!any_req && req_valid_i[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign tmo_hit = (cnt_q == TMO_W'(TMO_MAX - 1));
  assign rsp_hs  = rsp_ready_i[grant_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (dsp_done_i || tmo_hit) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      grant_q  <= '0;
      cfg_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q <= pick;
          cfg_q   <= req_cfg_i[pick*12 +: 12];
          data_q  <= req_data_i[pick*32 +: 32];
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // done wins over a simultaneous timeout
          if (dsp_done_i) begin
            status_q <= dsp_status_i;
            err_q    <= 1'b0;
          end else if (tmo_hit) begin
            status_q <= '0;
            err_q    <= 1'b1;
          end
        end
        RESP: if (rsp_hs) rr_q <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are forced to zero while reset_i is high so reset shows in its own cycle.
  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_status_o = '0;
    rsp_err_o    = 1'b0;
    dsp_start_o  = 1'b0;
    dsp_cfg_o    = '0;
    dsp_data_o   = '0;
    busy_o       = 1'b0;
    grant_o      = '0;
    if (!reset_i) begin
      if (state_q == IDLE && any_req) req_ready_o = NREQ'(1) << pick;
      if (state_q == RESP)            rsp_valid_o = NREQ'(1) << grant_q;
      rsp_status_o = status_q;
      rsp_err_o    = err_q;
      dsp_start_o  = (state_q == ISSUE);
      dsp_cfg_o    = cfg_q;
      dsp_data_o   = data_q;
      busy_o       = (state_q != IDLE);
      grant_o      = grant_q;
    end
  end

  a_rsp_onehot: assert property (@(posedge clk_i) $onehot0(rsp_valid_o));
  a_req_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));
  a_start_once: assert property (@(posedge clk_i) disable iff (reset_i)
                                 dsp_start_o |=> !dsp_start_o);

endmodule

// File: doc/xmpl_dsp_sched.md
Name: xmpl_dsp_sched

Overview:
Round-robin scheduler that shares one xmpl DSP datapath among NREQ requesters. Each requester submits a command: a 12-bit config word and a 32-bit operand. The scheduler grants one command at a time and drives the DSP start strobe, config and operand. It then waits for DSP completion, or a timeout, and returns the 32-bit status to the granted requester over a valid/ready response channel.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO_W, 8, width of the timeout counter
TMO_MAX, 200, DSP cycles allowed before a command is aborted (1..2^TMO_W-1)

Ports:
clk_i  in  1  single clock, rising edge
reset_i  in  1  reset; synchronous, active-high
req_valid_i  in  NREQ  per-requester command valid
req_ready_o  out  NREQ  per-requester command accept (one-hot or zero)
req_cfg_i  in  NREQ*12  per-requester config word, slice k = [12k+11:12k]
req_data_i  in  NREQ*32  per-requester operand, slice k = [32k+31:32k]
rsp_valid_o  out  NREQ  per-requester response valid (one-hot or zero)
rsp_ready_i  in  NREQ  per-requester response accept
rsp_status_o  out  32  status returned to the active requester
rsp_err_o  out  1  1 = command timed out; status is 0
dsp_start_o  out  1  one-cycle start strobe to the DSP
dsp_cfg_o  out  12  config word to the DSP
dsp_data_o  out  32  operand to the DSP
dsp_done_i  in  1  one-cycle DSP completion pulse
dsp_status_i  in  32  DSP status; valid in the cycle dsp_done_i=1
busy_o  out  1  1 in any state other than IDLE
grant_o  out  $clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Reset (reset_i=1 at a clock edge) takes effect in that same cycle and overrides all other inputs:
  - state=IDLE
  - all outputs 0
  - rr pointer=0, so requester 0 has highest priority first
  - any in-flight command is dropped, and a late dsp_done_i after reset is ignored
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, select the first set bit searching upward circularly from the rr pointer.
  - Assert req_ready_o[k] combinationally in that same cycle; the handshake occurs.
  - Latch cfg/data into internal registers, set grant_o=k, then go to ISSUE.
  - req_ready_o is 0 in all other states.
- ISSUE (exactly 1 cycle):
  - dsp_start_o=1; dsp_cfg_o/dsp_data_o present the latched values.
  - The latched values are held stable from ISSUE until the exit from WAIT.
  - Timeout counter is cleared to 0; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - dsp_done_i=1: capture dsp_status_i, rsp_err_o=0, go to RESP.
  - Else, if the counter reaches TMO_MAX: status=0, rsp_err_o=1, go to RESP.
  - Done arriving in the same cycle the counter reaches TMO_MAX counts as done (no error).
  - dsp_done_i in the ISSUE cycle is ignored; completion latency is ≥1 cycle after the start strobe.
- RESP:
  - rsp_valid_o[grant_o]=1; rsp_status_o/rsp_err_o are held stable until rsp_ready_i[grant_o]=1.
  - On that handshake: clear rsp_valid_o, set rr pointer = (grant_o+1) mod NREQ, go to IDLE.
  - rsp_ready_i on non-granted indices is ignored.
  - dsp_done_i in RESP/IDLE is ignored.
- Latency: request accept to dsp_start_o is 1 cycle. Best-case back-to-back throughput is one command per 4 cycles (done 1 cycle after start, response accepted immediately).
- Fairness: each requester is granted at most once before every other continuously-valid requester has been granted once.
- Deasserting req_valid_i while not granted is permitted and causes no side effects.
- rsp_status_o/rsp_err_o keep their last values outside RESP; rsp_valid_o qualifies them.
- Assertions: rsp_valid_o and req_ready_o are each $onehot0; dsp_start_o is never high two consecutive cycles.

Test Plan:
- Single command: reset 2 cycles; req_valid_i[1]=1, cfg=12'hA5C, data=32'h1234_5678.
  - Required: ready[1] in the same cycle; dsp_start_o next cycle with cfg/data matching.
  - Stimulus: dsp_done_i 3 cycles later, status=32'hDEAD_BEEF.
  - Required: rsp_valid_o=4'b0010, status DEAD_BEEF, err=0; busy_o drops after rsp_ready_i[1].
- Round-robin: all 4 req_valid_i held high; DSP done 1 cycle after each start; rsp_ready held high.
  - Required: grant order 0,1,2,3,0,1; start strobes exactly 4 cycles apart.
- Timeout: issue a command and never assert done.
  - Required: RESP entered on the cycle the counter hits 200, rsp_err_o=1, rsp_status_o=0.
  - Required: the next grant proceeds normally.
- Done at timeout boundary: dsp_done_i asserted on the same cycle the counter reaches TMO_MAX.
  - Required: err=0 and the DSP status is returned.
- Response backpressure: hold rsp_ready_i=0 for 10 cycles with another request pending.
  - Required: status stable, no new dsp_start_o, no req_ready_o; accept 1 cycle after rsp_ready_i.
- Reset mid-operation: assert reset_i during WAIT, then pulse dsp_done_i right after reset.
  - Required: all outputs 0 in the reset cycle, no response generated, and requester 0 is served first afterward.
